// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch unit, responder side of the fetch handshake.
//
// A one-cycle if_enable pulse in Idle starts a read of the word at pc over
// a req/ack memory bus. On ack the word is latched into instr, pc advances
// and if_ready pulses for one cycle. If no ack arrives within
// TIMEOUT_CYCLES Wait cycles, the fetch ends with if_ready and if_fault set
// and instr/instr_pc/pc unchanged. pc_load redirects pc from any state.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   if_enable               fetch start pulse (ignored unless Idle)
//   if_ready                one-cycle completion pulse (success or fault)
//   if_busy                 high while a fetch is in flight
//   if_fault                last fetch timed out
//   instr, instr_pc         last fetched word and its address
//   pc                      address of the next fetch
//   pc_load, pc_load_value  redirect request and target
//   mem_req, mem_addr       read request (held until ack) and address
//   mem_ack, mem_rdata      read data valid strobe and data
module cpu_fetch #(
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_enable,
  output logic                  if_ready,
  output logic                  if_busy,
  output logic                  if_fault,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] instr_q,    instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  if_ready_q, if_ready_d;
  logic                  if_busy_q,  if_busy_d;
  logic                  if_fault_q, if_fault_d;
  logic                  mem_req_q,  mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  // Set when pc was redirected during the current fetch; the completion
  // increment must then not overwrite the redirect target.
  logic                  redir_q,    redir_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if_ready_d = 1'b0;
    if_busy_d  = if_busy_q;
    if_fault_d = if_fault_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    redir_d    = redir_q;

    case (state_q)
      ST_IDLE: begin
        if (if_enable) begin
          state_d    = ST_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          if_busy_d  = 1'b1;
          if_fault_d = 1'b0;
          cnt_d      = '0;
          redir_d    = pc_load;
        end
      end
      ST_WAIT: begin
        if (pc_load) redir_d = 1'b1;
        if (mem_ack) begin
          state_d    = ST_DONE;
          instr_d    = mem_rdata;
          instr_pc_d = mem_addr_q;
          if (!redir_q) pc_d = mem_addr_q + ADDR_WIDTH'(1);
          mem_req_d  = 1'b0;
          if_busy_d  = 1'b0;
          if_ready_d = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          if_busy_d  = 1'b0;
          if_ready_d = 1'b1;
          if_fault_d = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect in the same cycle always wins over the completion increment.
    if (pc_load) pc_d = pc_load_value;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      if_ready_q <= 1'b0;
      if_busy_q  <= 1'b0;
      if_fault_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      redir_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      if_ready_q <= if_ready_d;
      if_busy_q  <= if_busy_d;
      if_fault_q <= if_fault_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      redir_q    <= redir_d;
    end
  end

  assign if_ready = if_ready_q;
  assign if_busy  = if_busy_q;
  assign if_fault = if_fault_q;
  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
  assign pc       = pc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;

  logic        clk;
  logic        reset_n;
  logic        if_enable;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        if_ready, if_busy, if_fault, mem_req;
  logic [31:0] instr;
  logic [15:0] instr_pc, pc, mem_addr;

  logic        t4_if_ready, t4_if_busy, t4_if_fault, t4_mem_req;
  logic [31:0] t4_instr;
  logic [15:0] t4_instr_pc, t4_pc, t4_mem_addr;

  int total = 0;
  int bad   = 0;

  cpu_fetch #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_enable    (if_enable),
    .if_ready     (if_ready),
    .if_busy      (if_busy),
    .if_fault     (if_fault),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc           (pc),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  // Second instance with the short timeout, sharing all inputs.
  cpu_fetch #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(4)
  ) dut_t4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .if_enable    (if_enable),
    .if_ready     (t4_if_ready),
    .if_busy      (t4_if_busy),
    .if_fault     (t4_if_fault),
    .instr        (t4_instr),
    .instr_pc     (t4_instr_pc),
    .pc           (t4_pc),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .mem_req      (t4_mem_req),
    .mem_addr     (t4_mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; if_enable = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", pc); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 16'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if ({if_ready, if_busy, if_fault, mem_req} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {if_ready, if_busy, if_fault, mem_req}); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait;
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL zw_addr got=%h exp=0000", mem_addr); end
    total++; if (if_busy !== 1'b1) begin bad++; $display("FAIL zw_busy got=%b exp=1", if_busy); end
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL zw_early_ready got=%b exp=0", if_ready); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL zw_ready got=%b exp=1", if_ready); end
    total++; if (instr !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_instr got=%h exp=deadbeef", instr); end
    total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL zw_instr_pc got=%h exp=0000", instr_pc); end
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL zw_pc got=%h exp=0001", pc); end
    total++; if ({mem_req, if_busy, if_fault} !== 3'b000) begin bad++; $display("FAIL zw_done_flags got=%b exp=000", {mem_req, if_busy, if_fault}); end
    tick();
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL zw_ready_pulse got=%b exp=0", if_ready); end
  endtask

  task automatic test_wait_states;
    int ready_cnt;
    ready_cnt = 0;
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin bad++; $display("FAIL ws_start got=%b/%h exp=1/0001", mem_req, mem_addr); end
    for (int i = 0; i < 5; i++) begin
      if_enable = (i == 1 || i == 3);
      tick();
      if_enable = 1'b0;
      total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || if_ready !== 1'b0) begin
        bad++; $display("FAIL ws_hold%0d got=%b/%h/%b exp=1/0001/0", i, mem_req, mem_addr, if_ready);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL ws_ready got=%b exp=1", if_ready); end
    total++; if (instr !== 32'h12345678) begin bad++; $display("FAIL ws_instr got=%h exp=12345678", instr); end
    total++; if (instr_pc !== 16'h0001 || pc !== 16'h0002) begin bad++; $display("FAIL ws_pc got=%h/%h exp=0001/0002", instr_pc, pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_ready === 1'b1 || mem_req === 1'b1) ready_cnt++;
    end
    total++; if (ready_cnt !== 0) begin bad++; $display("FAIL ws_no_extra_fetch got=%0d exp=0", ready_cnt); end
  endtask

  task automatic test_redirect;
    pc_load = 1'b1; pc_load_value = 16'h0003;
    tick();
    pc_load = 1'b0;
    total++; if (pc !== 16'h0003) begin bad++; $display("FAIL rd_idle_load got=%h exp=0003", pc); end
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_addr !== 16'h0003) begin bad++; $display("FAIL rd_addr3 got=%h exp=0003", mem_addr); end
    pc_load = 1'b1; pc_load_value = 16'h0100;
    tick();
    pc_load = 1'b0;
    total++; if (pc !== 16'h0100 || mem_addr !== 16'h0003 || mem_req !== 1'b1) begin
      bad++; $display("FAIL rd_wait_load got=%h/%h/%b exp=0100/0003/1", pc, mem_addr, mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0003;
    tick();
    mem_ack = 1'b0;
    total++; if (if_ready !== 1'b1 || instr_pc !== 16'h0003 || instr !== 32'hA5A5_0003) begin
      bad++; $display("FAIL rd_complete got=%b/%h/%h exp=1/0003/a5a50003", if_ready, instr_pc, instr);
    end
    total++; if (pc !== 16'h0100) begin bad++; $display("FAIL rd_pc_kept got=%h exp=0100", pc); end
    tick();
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_addr !== 16'h0100) begin bad++; $display("FAIL rd_next_addr got=%h exp=0100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0100; pc_load = 1'b1; pc_load_value = 16'h0200;
    tick();
    mem_ack = 1'b0; pc_load = 1'b0;
    total++; if (instr_pc !== 16'h0100 || pc !== 16'h0200) begin bad++; $display("FAIL rd_ack_load got=%h/%h exp=0100/0200", instr_pc, pc); end
    tick();
    if_enable = 1'b1; pc_load = 1'b1; pc_load_value = 16'h0300;
    tick();
    if_enable = 1'b0; pc_load = 1'b0;
    total++; if (mem_addr !== 16'h0200 || pc !== 16'h0300) begin bad++; $display("FAIL rd_enable_load got=%h/%h exp=0200/0300", mem_addr, pc); end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0200;
    tick();
    mem_ack = 1'b0;
    total++; if (instr_pc !== 16'h0200 || pc !== 16'h0300) begin bad++; $display("FAIL rd_enable_load_done got=%h/%h exp=0200/0300", instr_pc, pc); end
    tick();
  endtask

  task automatic test_timeout;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (t4_mem_req !== 1'b1 || t4_if_ready !== 1'b0) begin bad++; $display("FAIL to4_wait%0d got=%b/%b exp=1/0", i, t4_mem_req, t4_if_ready); end
      tick();
    end
    total++; if ({t4_if_ready, t4_if_fault, t4_mem_req, t4_if_busy} !== 4'b1100) begin
      bad++; $display("FAIL to4_fault got=%b exp=1100", {t4_if_ready, t4_if_fault, t4_mem_req, t4_if_busy});
    end
    total++; if (t4_instr !== 32'h0 || t4_pc !== 16'h0000 || t4_instr_pc !== 16'h0) begin
      bad++; $display("FAIL to4_unchanged got=%h/%h/%h exp=0/0/0", t4_instr, t4_pc, t4_instr_pc);
    end
    for (int i = 4; i < 8; i++) begin
      total++; if (mem_req !== 1'b1 || if_fault !== 1'b0) begin bad++; $display("FAIL to8_wait%0d got=%b/%b exp=1/0", i, mem_req, if_fault); end
      tick();
    end
    total++; if ({if_ready, if_fault, mem_req} !== 3'b110) begin bad++; $display("FAIL to8_fault got=%b exp=110", {if_ready, if_fault, mem_req}); end
    total++; if (t4_if_ready !== 1'b0 || t4_if_fault !== 1'b1) begin bad++; $display("FAIL to4_after got=%b/%b exp=0/1", t4_if_ready, t4_if_fault); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0;
    total++; if (if_ready !== 1'b0 || instr !== 32'h0 || if_fault !== 1'b1 || pc !== 16'h0000) begin
      bad++; $display("FAIL to_late_ack got=%b/%h/%b/%h exp=0/0/1/0000", if_ready, instr, if_fault, pc);
    end
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (if_fault !== 1'b0 || t4_if_fault !== 1'b0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL to_fault_clear got=%b/%b/%b exp=0/0/1", if_fault, t4_if_fault, mem_req);
    end
    for (int i = 0; i < 7; i++) tick();
    total++; if (mem_req !== 1'b1 || if_ready !== 1'b0) begin bad++; $display("FAIL to_thresh_wait got=%b/%b exp=1/0", mem_req, if_ready); end
    mem_ack = 1'b1; mem_rdata = 32'hC0DE0007;
    tick();
    mem_ack = 1'b0;
    total++; if ({if_ready, if_fault} !== 2'b10 || instr !== 32'hC0DE0007 || pc !== 16'h0001) begin
      bad++; $display("FAIL to_thresh_ack got=%b/%h/%h exp=10/c0de0007/0001", {if_ready, if_fault}, instr, pc);
    end
    tick();
  endtask

  task automatic test_wrap;
    pc_load = 1'b1; pc_load_value = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr got=%h exp=ffff", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0F0F0F0F;
    tick();
    mem_ack = 1'b0;
    total++; if (instr_pc !== 16'hFFFF || pc !== 16'h0000 || if_fault !== 1'b0) begin
      bad++; $display("FAIL wrap_pc got=%h/%h/%b exp=ffff/0000/0", instr_pc, pc, if_fault);
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch;
    pc_load = 1'b1; pc_load_value = 16'h0050;
    tick();
    pc_load = 1'b0;
    if_enable = 1'b1;
    tick();
    if_enable = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0050) begin bad++; $display("FAIL rm_start got=%b/%h exp=1/0050", mem_req, mem_addr); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (mem_req !== 1'b0 || pc !== 16'h0000 || if_busy !== 1'b0 || instr !== 32'h0) begin
      bad++; $display("FAIL rm_reset got=%b/%h/%b/%h exp=0/0000/0/0", mem_req, pc, if_busy, instr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    mem_ack = 1'b0;
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL rm_late_ack got=%b exp=0", if_ready); end
    tick();
    total++; if (if_ready !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h0) begin
      bad++; $display("FAIL rm_quiet got=%b/%b/%h exp=0/0/0", if_ready, mem_req, instr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_timeout();
    test_wrap();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
